// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types, CRC constants and width helper for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned CRC_W    = 16;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Host-side bitstream word channel with valid/ready handshake.
interface ccff_bitstream_loader_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/ccff_bitstream_loader_crc16.sv
// Serial-input CRC-16-CCITT accumulator over the chain tail (used with CCFF_READBACK_EN).
module ccff_crc16
  import ccff_loader_pkg::*;
(
  input  logic             prog_clk,
  input  logic             prog_reset,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic feedback_c;
  assign feedback_c = crc[CRC_W-1] ^ din;

  always_ff @(posedge prog_clk) begin
    if (prog_reset || clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (feedback_c ? CRC_POLY : CRC_W'(0));
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes host bitstream words MSB-first into the configuration flip-flop chain.
// Optional CCFF_READBACK_EN adds a CRC-16 of the bits emerging from ccff_tail.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned DATA_W    = 8
) (
`ifdef CCFF_READBACK_EN
  output logic [15:0]             readback_crc,
`endif
  input  logic                    prog_clk,
  input  logic                    prog_reset,
  input  logic                    start,
  ccff_bitstream_loader_if.slave  host,
  output logic                    ccff_head,
  output logic                    prog_clk_en,
  input  logic                    ccff_tail,
  output logic                    busy,
  output logic                    cfg_done
);

  localparam int unsigned NUM_WORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int unsigned BIT_W     = cnt_w(CHAIN_LEN + 1);
  localparam int unsigned WORD_W    = cnt_w(NUM_WORDS + 1);
  localparam int unsigned REM_W     = cnt_w(DATA_W);

  state_t             state;
  logic [DATA_W-1:0]  sreg;
  logic [DATA_W-1:0]  hold;
  logic               hold_full;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]  word_cnt;
  logic [REM_W-1:0]   rem;

  logic               start_ok_c;
  logic               accept_c;
  logic               word_end_c;
  logic [BIT_W-1:0]   bit_cnt_inc_c;

  assign host.s_ready  = busy && !hold_full && (word_cnt < WORD_W'(NUM_WORDS));
  assign accept_c      = host.s_valid && host.s_ready;
  assign start_ok_c    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign word_end_c    = (rem == '0);
  assign bit_cnt_inc_c = bit_cnt + BIT_W'(1);

  // Control and datapath; prog_clk_en is re-armed only on cycles that present a bit.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state       <= ST_IDLE;
      sreg        <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      rem         <= '0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
      busy        <= 1'b0;
      cfg_done    <= 1'b0;
    end else begin
      prog_clk_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok_c) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            cfg_done  <= 1'b0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            rem       <= '0;
          end
        end

        ST_LOAD: begin
          if (accept_c) begin
            ccff_head   <= host.s_data[DATA_W-1];
            sreg        <= {host.s_data[DATA_W-2:0], 1'b0};
            rem         <= REM_W'(DATA_W - 1);
            word_cnt    <= word_cnt + WORD_W'(1);
            prog_clk_en <= 1'b1;
            state       <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          bit_cnt <= bit_cnt_inc_c;
          // A word arriving exactly at a starved word boundary bypasses the holding register.
          if (accept_c && !(word_end_c && !hold_full)) begin
            hold      <= host.s_data;
            hold_full <= 1'b1;
            word_cnt  <= word_cnt + WORD_W'(1);
          end
          if (bit_cnt_inc_c == BIT_W'(CHAIN_LEN)) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            cfg_done <= 1'b1;
          end else if (!word_end_c) begin
            ccff_head   <= sreg[DATA_W-1];
            sreg        <= {sreg[DATA_W-2:0], 1'b0};
            rem         <= rem - REM_W'(1);
            prog_clk_en <= 1'b1;
          end else if (hold_full) begin
            ccff_head   <= hold[DATA_W-1];
            sreg        <= {hold[DATA_W-2:0], 1'b0};
            rem         <= REM_W'(DATA_W - 1);
            hold_full   <= 1'b0;
            prog_clk_en <= 1'b1;
          end else if (accept_c) begin
            ccff_head   <= host.s_data[DATA_W-1];
            sreg        <= {host.s_data[DATA_W-2:0], 1'b0};
            rem         <= REM_W'(DATA_W - 1);
            word_cnt    <= word_cnt + WORD_W'(1);
            prog_clk_en <= 1'b1;
          end else begin
            state <= ST_LOAD;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  ccff_crc16 u_crc (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear      (start_ok_c),
    .en         (prog_clk_en),
    .din        (ccff_tail),
    .crc        (readback_crc)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed plus randomized bench for ccff_bitstream_loader with a chain model on ccff_tail.
module tb_ccff_bitstream_loader;

  localparam int unsigned CHAIN_LEN = 20;
  localparam int unsigned DATA_W    = 8;

  logic prog_clk = 1'b0;
  logic prog_reset, start, ccff_head, prog_clk_en, ccff_tail, busy, cfg_done;
`ifdef CCFF_READBACK_EN
  logic [15:0] readback_crc;
`endif

  ccff_bitstream_loader_if #(.DATA_W(DATA_W)) host_bus ();

  ccff_bitstream_loader #(.CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W)) dut (
`ifdef CCFF_READBACK_EN
    .readback_crc (readback_crc),
`endif
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start        (start),
    .host         (host_bus),
    .ccff_head    (ccff_head),
    .prog_clk_en  (prog_clk_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .cfg_done     (cfg_done)
  );

  always #5 prog_clk = ~prog_clk;

  int total = 0;
  int bad   = 0;

  // chain[CHAIN_LEN-1:0] is the physical chain (index 0 newest); chain[CHAIN_LEN] holds
  // the bit that left the tail on the last shift, which is what the DUT samples.
  logic [CHAIN_LEN:0]   chain = '0;
  logic [CHAIN_LEN-1:0] cap_bits = '0;
  bit                   emerge_q[$];
  int cyc = 0, en_cnt = 0, first_en = -1, last_en = -1, done_cyc = -1;
  logic done_q = 1'b0;

  assign ccff_tail = chain[CHAIN_LEN];

  always @(negedge prog_clk) begin
    cyc++;
    if (prog_clk_en === 1'b1) begin
      if (en_cnt == 0) first_en = cyc;
      last_en = cyc;
      en_cnt++;
      cap_bits = {cap_bits[CHAIN_LEN-2:0], ccff_head};
      chain    = {chain[CHAIN_LEN-1:0], ccff_head};
      emerge_q.push_back(chain[CHAIN_LEN]);
    end
    if (cfg_done === 1'b1 && !done_q) done_cyc = cyc;
    done_q = (cfg_done === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [CHAIN_LEN-1:0] ref_bits(input logic [7:0] w0, input logic [7:0] w1,
                                                   input logic [7:0] w2);
    logic [7:0] ws [3];
    logic [CHAIN_LEN-1:0] r = '0;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    for (int i = 0; i < int'(CHAIN_LEN); i++)
      r = {r[CHAIN_LEN-2:0], ws[i / DATA_W][DATA_W - 1 - (i % DATA_W)]};
    return r;
  endfunction

  function automatic logic [15:0] ref_crc();
    logic [15:0] c = 16'hFFFF;
    logic fb;
    foreach (emerge_q[k]) begin
      fb = c[15] ^ emerge_q[k];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic tick();
    @(negedge prog_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0; first_en = -1; last_en = -1; done_cyc = -1;
    cap_bits = '0;
    emerge_q.delete();
  endtask

  task automatic pulse_start();
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    host_bus.s_valid = 1'b1;
    host_bus.s_data  = w;
    while (host_bus.s_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("send_ready", 32'(host_bus.s_ready), 32'd1);
    tick();
  endtask

  task automatic wait_done();
    int n = 0;
    while (cfg_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("done_wait", 32'(cfg_done), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_head"},  32'(ccff_head), 32'd0);
    chk({tag, "_en"},    32'(prog_clk_en), 32'd0);
    chk({tag, "_ready"}, 32'(host_bus.s_ready), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(cfg_done), 32'd0);
`ifdef CCFF_READBACK_EN
    chk({tag, "_crc"},   32'(readback_crc), 32'hFFFF);
`endif
  endtask

  task automatic check_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2);
    chk({tag, "_bits"},    32'(cap_bits), 32'(ref_bits(w0, w1, w2)));
    chk({tag, "_enables"}, en_cnt, CHAIN_LEN);
    chk({tag, "_done_lat"}, done_cyc, last_en + 1);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_ready"},   32'(host_bus.s_ready), 32'd0);
`ifdef CCFF_READBACK_EN
    chk({tag, "_crc"},     32'(readback_crc), 32'(ref_crc()));
`endif
  endtask

  task automatic run_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int gap_max);
    logic [7:0] ws [3];
    int g;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    for (int i = 0; i < 3; i++) begin
      send(ws[i]);
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0 || i == 2) host_bus.s_valid = 1'b0;
      repeat (g) tick();
    end
    host_bus.s_valid = 1'b0;
    wait_done();
    check_load(tag, w0, w1, w2);
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    logic saw_ready;
    int n;

    prog_reset = 1'b1; start = 1'b0;
    host_bus.s_valid = 1'b0; host_bus.s_data = '0;
    repeat (3) tick();
    prog_reset = 1'b0;
    tick();
    check_reset("reset");

    // Back-to-back words from the reference pattern.
    pulse_start();
    chk("t1_start_busy",  32'(busy), 32'd1);
    chk("t1_start_ready", 32'(host_bus.s_ready), 32'd1);
    send(8'hA5);
    chk("t1_first_en",   32'(prog_clk_en), 32'd1);
    chk("t1_first_head", 32'(ccff_head), 32'd1);
    send(8'h3C);
    send(8'hF0);
    host_bus.s_valid = 1'b0;
    wait_done();
    check_load("t1", 8'hA5, 8'h3C, 8'hF0);
    chk("t1_contiguous", last_en - first_en + 1, CHAIN_LEN);

    // Same words with 3-cycle valid gaps; CRC reads back the first pattern.
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send((i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'hF0);
      host_bus.s_valid = 1'b0;
      repeat (3) tick();
    end
    wait_done();
    check_load("t2", 8'hA5, 8'h3C, 8'hF0);
`ifdef CCFF_READBACK_EN
    repeat (4) tick();
    chk("t2_crc_stable", 32'(readback_crc), 32'(ref_crc()));
`endif

    // Fourth word offered after three were accepted must never be taken.
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    pulse_start();
    send(r0); send(r1); send(r2);
    host_bus.s_data = 8'h77;
    saw_ready = 1'b0;
    repeat (40) begin
      tick();
      if (host_bus.s_ready === 1'b1) saw_ready = 1'b1;
    end
    host_bus.s_valid = 1'b0;
    chk("t3_no_4th_ready", 32'(saw_ready), 32'd0);
    wait_done();
    check_load("t3", r0, r1, r2);

    // Reset after 9 shifted bits, then a normal reload.
    pulse_start();
    send(8'($urandom)); send(8'($urandom));
    host_bus.s_valid = 1'b0;
    n = 0;
    while (en_cnt < 9 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_nine_bits", en_cnt, 9);
    prog_reset = 1'b1;
    tick();
    prog_reset = 1'b0;
    check_reset("t4_reset");
    chk("t4_no_extra_en", en_cnt, 9);
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    pulse_start();
    run_load("t4_reload", r0, r1, r2, 0);

    // Start during SHIFT is ignored.
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    pulse_start();
    send(r0); send(r1);
    host_bus.s_valid = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_busy_kept", 32'(busy), 32'd1);
    send(r2);
    host_bus.s_valid = 1'b0;
    wait_done();
    check_load("t5", r0, r1, r2);

    // Start in DONE, then randomized loads with random gaps (some starve the shifter).
    for (int k = 0; k < 4; k++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      pulse_start();
      chk("t6_done_drop", 32'(cfg_done), 32'd0);
      chk("t6_busy",      32'(busy), 32'd1);
      chk("t6_ready",     32'(host_bus.s_ready), 32'd1);
      run_load("t6", r0, r1, r2, 12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
